uart_cmd_rx: RTL

//  - UART byte receiver and command front end for the echo canceller control path.
//  - Deserialises the PC/RS232 line into bytes on clk.
//  - Presents each good byte on rs232_data with a one-cycle rs232_flag strobe.
//  - The echo canceller stage consumes rs232_data[7:0] (delay/attenuation command codes) and rs232_flag.

---
 rtl/uart_cmd_rx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_cmd_rx.sv
// UART byte receiver (8N1, or 8E1 when UART_PARITY_CHECK_EN is defined) feeding
// command bytes to the echo canceller; good bytes strobe rs232_flag, bad frames rx_err.
module uart_cmd_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [8:0] rs232_data,
  output logic       rs232_flag,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam int BIT_CNT_MAX = CLK_FREQ / BAUD_RATE;
  localparam int HALF        = BIT_CNT_MAX / 2;
  localparam int CNT_W       = (BIT_CNT_MAX > 1) ? $clog2(BIT_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state_reg, state_next;
  logic             rxd_meta, rxd_s, rxd_d;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             fall, tick_mid, tick_bit, stop_ok;
`ifdef UART_PARITY_CHECK_EN
  logic             par_err_reg;
`endif

  // Line synchroniser plus one delay stage for start-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_d    <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      rxd_d    <= rxd_s;
    end
  end

  assign fall     = rxd_d & ~rxd_s;
  assign tick_mid = (cnt_reg == CNT_MID);
  assign tick_bit = (cnt_reg == CNT_LAST);
`ifdef UART_PARITY_CHECK_EN
  assign stop_ok  = rxd_s & ~par_err_reg;
`else
  assign stop_ok  = rxd_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (fall) state_next = START;
      START:     if (tick_mid) state_next = rxd_s ? IDLE : DATA;
      DATA: begin
        if (tick_bit && bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_CHECK_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_PARITY_CHECK_EN
      PARITY:    if (tick_bit) state_next = STOP;
`endif
      STOP:      if (tick_bit) state_next = stop_ok ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath: baud counter, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      rs232_data  <= 9'h000;
      rs232_flag  <= 1'b0;
      rx_err      <= 1'b0;
      rx_busy     <= 1'b0;
`ifdef UART_PARITY_CHECK_EN
      par_err_reg <= 1'b0;
`endif
    end else begin
      rs232_flag <= 1'b0;
      rx_err     <= 1'b0;
      rx_busy    <= (state_next != IDLE);

      // Every state change restarts the bit timing from zero
      if (state_next != state_reg || state_reg == IDLE || state_reg == WAIT_HIGH)
        cnt_reg <= '0;
      else if (tick_bit)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;

      if (state_reg == START) begin
        bit_idx_reg <= 3'd0;
`ifdef UART_PARITY_CHECK_EN
        par_err_reg <= 1'b0;
`endif
      end

      if (state_reg == DATA && tick_bit) begin
        shift_reg   <= {rxd_s, shift_reg[7:1]};
        bit_idx_reg <= bit_idx_reg + 3'd1;
      end

`ifdef UART_PARITY_CHECK_EN
      if (state_reg == PARITY && tick_bit)
        par_err_reg <= (^shift_reg) ^ rxd_s;
`endif

      if (state_reg == STOP && tick_bit) begin
        rs232_data <= {~stop_ok, shift_reg};
        rs232_flag <= stop_ok;
        rx_err     <= ~stop_ok;
      end
    end
  end

endmodule
